// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: RV32I access codes,
// FSM state type and byte-lane helpers for store/load formatting.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misalignment and illegal encodings collapse into one error flag;
    // unsigned loads have no store counterpart.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
        case (f3)
            F3_B:    return 1'b0;
            F3_H:    return off[0];
            F3_W:    return off != 2'b00;
            F3_BU:   return we;
            F3_HU:   return we | off[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] wd);
        case (f3)
            F3_B:    return {4{wd[7:0]}};
            F3_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  lane;
        logic [15:0] half;
        lane = word[{off, 3'b000} +: 8];
        half = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{lane[7]}}, lane};
            F3_BU:   return {24'd0, lane};
            F3_H:    return {{16{half[15]}}, half};
            F3_HU:   return {16'd0, half};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-enable synchronous write and
// combinational read on a single shared word address.
module dmem_array #(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I load/store controller with a fixed number of wait states between
// request accept and a one-cycle response pulse.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic          accept;
    logic          go_resp;
    logic          cur_we;
    logic [2:0]    cur_f3;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic          err_d;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic [31:0]   rsp_rdata_d;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:AW+2];
    assign accept         = req_valid && (state_q == IDLE);

    // With zero wait states the access resolves in the accept cycle, so
    // decode works from the live request instead of the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_f3    = req_funct3;
            cur_addr  = req_addr[AW+1:0];
            cur_wdata = req_wdata;
        end else begin
            cur_we    = we_q;
            cur_f3    = f3_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    assign go_resp     = (accept && (WAIT_CYCLES == 0)) ||
                         ((state_q == WAIT) && (cnt_q == 4'd0));
    assign err_d       = access_err(cur_we, cur_f3, cur_addr[1:0]);
    assign mem_be      = (go_resp && cur_we && !err_d && !rst) ?
                         store_be(cur_f3, cur_addr[1:0]) : 4'b0000;
    assign rsp_rdata_d = (err_d || cur_we) ? 32'd0 :
                         load_extract(cur_f3, cur_addr[1:0], mem_rdata);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .be_i   (mem_be),
        .addr_i (cur_addr[AW+1:2]),
        .wdata_i(store_data(cur_f3, cur_wdata)),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
            if (go_resp) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= err_d;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
